// File: rtl/ram_nibble_ctrl_pkg.sv
// Shared definitions for the 256x4 nibble RAM access controller:
// array geometry, pin polarities, controller states and a sizing helper.
package ram_nibble_pkg;

  localparam int RAM_AW = 8;
  localparam int RAM_DW = 4;

  // Active levels of the RAM strobes
  localparam logic CS1_ACT = 1'b0;
  localparam logic CS2_ACT = 1'b1;
  localparam logic W_ACT   = 1'b0;
  localparam logic OE_ACT  = 1'b0;

  typedef enum logic [2:0] {
    CLR_SETUP = 3'd0,
    CLR_PULSE = 3'd1,
    CLR_HOLD  = 3'd2,
    IDLE      = 3'd3,
    W_SETUP   = 3'd4,
    W_PULSE   = 3'd5,
    W_HOLD    = 3'd6,
    R_WAIT    = 3'd7
  } state_e;

  // Largest of the four timing parameters; sizes the shared down-counter
  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ram_nibble_ctrl_if.sv
// System-bus side of the nibble RAM controller.
//
// Handshake: the master presents req with we/addr/wdata; a transfer is
// accepted on any rising clock edge where req && ready. ready stays low
// from acceptance until the access completes; done pulses for exactly one
// cycle at completion (ready is already high again in that cycle). Inputs
// are only looked at on the accepting edge. rdata is valid from a read's
// done and held until the next read's done. clr_busy is high while the
// post-reset zero-fill runs; req is ignored throughout it.
interface ram_nibble_ctrl_if;
  import ram_nibble_pkg::*;

  logic              req;
  logic              we;
  logic [RAM_AW-1:0] addr;
  logic [RAM_DW-1:0] wdata;
  logic              ready;
  logic              done;
  logic [RAM_DW-1:0] rdata;
  logic              clr_busy;
  state_e            state_dbg;

  modport master (
    output req, we, addr, wdata,
    input  ready, done, rdata, clr_busy, state_dbg
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, done, rdata, clr_busy, state_dbg
  );

endinterface

// File: rtl/ram_nibble_ctrl.sv
// Access controller for a 256x4 static nibble RAM. Turns single-cycle
// req/ready transfers into chip-select / write-strobe / output-enable
// sequences, captures read nibbles and optionally zero-fills the array
// after reset. Every RAM pin and bus output comes straight from a flop.
module ram_nibble_ctrl
  import ram_nibble_pkg::*;
#(
  parameter int WR_SETUP       = 1,
  parameter int WR_PULSE       = 2,
  parameter int WR_HOLD        = 1,
  parameter int RD_WAIT        = 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  ram_nibble_ctrl_if.slave  bus,
  output logic [RAM_AW-1:0] ram_a,
  output logic [RAM_DW-1:0] ram_i,
  input  logic [RAM_DW-1:0] ram_d,
  output logic              ram_cs1,
  output logic              ram_cs2,
  output logic              ram_w,
  output logic              ram_oe
);

  localparam int MAXP = max_of4(WR_SETUP, WR_PULSE, WR_HOLD, RD_WAIT);
  localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

  typedef logic [CW-1:0] cnt_t;

  // Counter reload values: a phase of N cycles counts N-1 down to 0
  localparam cnt_t LD_WS = cnt_t'(WR_SETUP - 1);
  localparam cnt_t LD_WP = cnt_t'(WR_PULSE - 1);
  localparam cnt_t LD_WH = cnt_t'(WR_HOLD - 1);
  localparam cnt_t LD_RD = cnt_t'(RD_WAIT - 1);

  state_e state;
  cnt_t   cnt;
  logic   ready_q;
  logic   done_q;
  logic   clr_busy_q;
  logic [RAM_DW-1:0] rdata_q;

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.clr_busy  = clr_busy_q;
  assign bus.state_dbg = state;

  // Controller FSM: sequences strobes from the phase counter; reset drops
  // every strobe at once so an interrupted write pulse cannot survive it.
  // The cycle right after reset release already counts as the first setup
  // cycle of address 0 when the zero-fill is enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= CLEAR_ON_RESET ? CLR_SETUP : IDLE;
      cnt        <= CLEAR_ON_RESET ? LD_WS : '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      rdata_q    <= '0;
      clr_busy_q <= CLEAR_ON_RESET;
      ram_a      <= '0;
      ram_i      <= '0;
      ram_cs1    <= ~CS1_ACT;
      ram_cs2    <= ~CS2_ACT;
      ram_w      <= ~W_ACT;
      ram_oe     <= ~OE_ACT;
    end else begin
      done_q <= 1'b0;
      case (state)
        CLR_SETUP: begin
          ram_cs1 <= CS1_ACT;
          ram_cs2 <= CS2_ACT;
          ram_i   <= '0;
          if (cnt == '0) begin
            state <= CLR_PULSE;
            cnt   <= LD_WP;
            ram_w <= W_ACT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CLR_PULSE: begin
          if (cnt == '0) begin
            state <= CLR_HOLD;
            cnt   <= LD_WH;
            ram_w <= ~W_ACT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CLR_HOLD: begin
          if (cnt == '0) begin
            if (ram_a == '1) begin
              state      <= IDLE;
              ram_cs1    <= ~CS1_ACT;
              ram_cs2    <= ~CS2_ACT;
              clr_busy_q <= 1'b0;
              ready_q    <= 1'b1;
            end else begin
              // next address follows with no deselect gap
              state <= CLR_SETUP;
              cnt   <= LD_WS;
              ram_a <= ram_a + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        IDLE: begin
          ram_cs1 <= ~CS1_ACT;
          ram_cs2 <= ~CS2_ACT;
          ram_w   <= ~W_ACT;
          ram_oe  <= ~OE_ACT;
          ready_q <= 1'b1;
          if (bus.req && ready_q) begin
            ram_a   <= bus.addr;
            ram_i   <= bus.wdata;
            ram_cs1 <= CS1_ACT;
            ram_cs2 <= CS2_ACT;
            ready_q <= 1'b0;
            if (bus.we) begin
              state <= W_SETUP;
              cnt   <= LD_WS;
            end else begin
              state  <= R_WAIT;
              cnt    <= LD_RD;
              ram_oe <= OE_ACT;
            end
          end
        end
        W_SETUP: begin
          if (cnt == '0) begin
            state <= W_PULSE;
            cnt   <= LD_WP;
            ram_w <= W_ACT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        W_PULSE: begin
          if (cnt == '0) begin
            state <= W_HOLD;
            cnt   <= LD_WH;
            ram_w <= ~W_ACT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        W_HOLD: begin
          if (cnt == '0) begin
            state   <= IDLE;
            ram_cs1 <= ~CS1_ACT;
            ram_cs2 <= ~CS2_ACT;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        R_WAIT: begin
          if (cnt == '0) begin
            state   <= IDLE;
            rdata_q <= ram_d;
            ram_cs1 <= ~CS1_ACT;
            ram_cs2 <= ~CS2_ACT;
            ram_oe  <= ~OE_ACT;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_nibble_ctrl.sv
// Bench for ram_nibble_ctrl: a default instance (with zero-fill) and a
// second instance with WR_PULSE=3, RD_WAIT=1 and no zero-fill, each wired
// to a behavioural nibble RAM. Expected data comes from a plain array
// model of memory contents plus a read-data queue; expected pin timing
// comes from the parameter values.
module tb_ram_nibble_ctrl;
  import ram_nibble_pkg::*;

  localparam int WS  = 1;
  localparam int WP  = 2;
  localparam int WH  = 1;
  localparam int RD  = 2;
  localparam int PER = WS + WP + WH;

  localparam int BWS = 1;
  localparam int BWP = 3;
  localparam int BWH = 1;
  localparam int BRD = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  // ---------------- DUT A (defaults) ----------------
  ram_nibble_ctrl_if bus_a ();
  logic [7:0] a_a;
  logic [3:0] a_i, a_d;
  logic a_cs1, a_cs2, a_w, a_oe;
  logic cs_a;
  assign cs_a = !a_cs1 && a_cs2;

  ram_nibble_ctrl dut_a (
    .clk(clk), .reset_n(rst_a), .bus(bus_a),
    .ram_a(a_a), .ram_i(a_i), .ram_d(a_d),
    .ram_cs1(a_cs1), .ram_cs2(a_cs2), .ram_w(a_w), .ram_oe(a_oe)
  );

  // ---------------- DUT B (long pulse, short read, no clear) ----------------
  ram_nibble_ctrl_if bus_b ();
  logic [7:0] b_a;
  logic [3:0] b_i, b_d;
  logic b_cs1, b_cs2, b_w, b_oe;
  logic cs_b;
  assign cs_b = !b_cs1 && b_cs2;

  ram_nibble_ctrl #(.WR_SETUP(BWS), .WR_PULSE(BWP), .WR_HOLD(BWH),
                    .RD_WAIT(BRD), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk(clk), .reset_n(rst_b), .bus(bus_b),
    .ram_a(b_a), .ram_i(b_i), .ram_d(b_d),
    .ram_cs1(b_cs1), .ram_cs2(b_cs2), .ram_w(b_w), .ram_oe(b_oe)
  );

  // ---------------- behavioural RAM devices ----------------
  logic [3:0] mem_a [256];
  logic [3:0] mem_b [256];

  always @(negedge clk) begin
    if (!a_w && cs_a) mem_a[a_a] = a_i;
    if (!b_w && cs_b) mem_b[b_a] = b_i;
  end

  assign a_d = (cs_a && !a_oe) ? mem_a[a_a] : 4'h0;
  assign b_d = (cs_b && !b_oe) ? mem_b[b_a] : 4'h0;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] ref_a [256];
  logic [3:0] exp_q [$];
  logic [3:0] last_rd = 4'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pin-level safety rules, checked every cycle outside reset
  always @(negedge clk) begin
    if (rst_a) begin
      check("a_w_without_cs", 32'(a_w || cs_a), 32'd1);
      check("a_w_with_oe", 32'(a_w || a_oe), 32'd1);
    end
    if (rst_b) begin
      check("b_w_without_cs", 32'(b_w || cs_b), 32'd1);
      check("b_w_with_oe", 32'(b_w || b_oe), 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  // Release reset on A and follow the zero-fill cycle by cycle
  task automatic release_and_sweep_a();
    int n;
    @(negedge clk);
    rst_a = 1'b1;
    bus_a.req   = 1'b1;
    bus_a.we    = 1'b1;
    bus_a.addr  = 8'($urandom_range(0, 255));
    bus_a.wdata = 4'($urandom_range(1, 15));
    n = 0;
    while (bus_a.clr_busy && n < 2000) begin
      check("sw_addr", 32'(a_a), 32'(n / PER));
      check("sw_data", 32'(a_i), 32'd0);
      check("sw_cs", 32'(cs_a), 32'(n >= 1));
      check("sw_w_low", 32'(!a_w), 32'((n % PER) >= WS && (n % PER) < WS + WP));
      check("sw_ready", 32'(bus_a.ready), 32'd0);
      check("sw_done", 32'(bus_a.done), 32'd0);
      n++;
      @(negedge clk);
    end
    bus_a.req = 1'b0;
    check("sw_length", 32'(n), 32'(256 * PER));
    check("sw_ready_rise", 32'(bus_a.ready), 32'd1);
    check("sw_cs_off", 32'(cs_a), 32'd0);
    check("sw_no_done", 32'(bus_a.done), 32'd0);
    for (int i = 0; i < 256; i++) ref_a[i] = 4'h0;
  endtask

  // One access on A, checked phase by phase; ends at the done-cycle negedge
  task automatic access_a(input bit wr, input logic [7:0] ad, input logic [3:0] wd, input bit b2b);
    int k;
    int lat;
    logic [3:0] e;
    if (b2b) begin
      check("b2b_ready", 32'(bus_a.ready), 32'd1);
    end else begin
      k = 0;
      while (!bus_a.ready && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("ready_wait", 32'(bus_a.ready), 32'd1);
    end
    bus_a.req   = 1'b1;
    bus_a.we    = wr;
    bus_a.addr  = ad;
    bus_a.wdata = wd;
    if (wr) ref_a[ad] = wd;
    else exp_q.push_back(ref_a[ad]);
    @(posedge clk);
    #1;
    bus_a.req   = 1'b0;
    bus_a.we    = 1'($urandom_range(0, 1));
    bus_a.addr  = 8'($urandom_range(0, 255));
    bus_a.wdata = 4'($urandom_range(0, 15));
    lat = wr ? PER + 1 : RD + 1;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c < lat) begin
        check("busy_done", 32'(bus_a.done), 32'd0);
        check("busy_ready", 32'(bus_a.ready), 32'd0);
        check("busy_cs", 32'(cs_a), 32'd1);
        check("busy_addr", 32'(a_a), 32'(ad));
        check("rdata_hold", 32'(bus_a.rdata), 32'(last_rd));
        if (wr) begin
          check("wr_data", 32'(a_i), 32'(wd));
          check("wr_w_low", 32'(!a_w), 32'(c > WS && c <= WS + WP));
          check("wr_oe", 32'(a_oe), 32'd1);
        end else begin
          check("rd_oe", 32'(a_oe), 32'd0);
          check("rd_w", 32'(a_w), 32'd1);
        end
        // requests while busy must be ignored
        bus_a.req  = 1'($urandom_range(0, 1));
        bus_a.we   = 1'($urandom_range(0, 1));
        bus_a.addr = 8'($urandom_range(0, 255));
      end else begin
        bus_a.req = 1'b0;
        check("done_pulse", 32'(bus_a.done), 32'd1);
        check("done_ready", 32'(bus_a.ready), 32'd1);
        check("done_cs_off", 32'(cs_a), 32'd0);
        check("done_w", 32'(a_w), 32'd1);
        check("done_oe", 32'(a_oe), 32'd1);
        if (!wr) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'h0;
          check("rd_data", 32'(bus_a.rdata), 32'(e));
          last_rd = e;
        end else begin
          check("rdata_hold_wr", 32'(bus_a.rdata), 32'(last_rd));
        end
      end
    end
  endtask

  // One access on B; reports latency to done and number of w-low cycles
  task automatic access_b(input bit wr, input logic [7:0] ad, input logic [3:0] wd,
                          output int lat, output int wlow);
    @(negedge clk);
    bus_b.req   = 1'b1;
    bus_b.we    = wr;
    bus_b.addr  = ad;
    bus_b.wdata = wd;
    @(posedge clk);
    #1;
    bus_b.req = 1'b0;
    lat  = 0;
    wlow = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!b_w) wlow++;
    end while (!bus_b.done && lat < 20);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int wl;
    logic [7:0] ad;
    logic [3:0] wd;
    bit wr;
    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.req = 1'b0; bus_a.we = 1'b0; bus_a.addr = '0; bus_a.wdata = '0;
    bus_b.req = 1'b0; bus_b.we = 1'b0; bus_b.addr = '0; bus_b.wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 4'($urandom_range(1, 15));
      mem_b[i] = 4'($urandom_range(0, 15));
      ref_a[i] = 4'h0;
    end
    #12;
    check("rst_ready", 32'(bus_a.ready), 32'd0);
    check("rst_done", 32'(bus_a.done), 32'd0);
    check("rst_rdata", 32'(bus_a.rdata), 32'd0);
    check("rst_clr_busy", 32'(bus_a.clr_busy), 32'd1);
    check("rst_ram_a", 32'(a_a), 32'd0);
    check("rst_ram_i", 32'(a_i), 32'd0);
    check("rst_cs1", 32'(a_cs1), 32'd1);
    check("rst_cs2", 32'(a_cs2), 32'd0);
    check("rst_w", 32'(a_w), 32'd1);
    check("rst_oe", 32'(a_oe), 32'd1);
    check("rst_state_a", 32'(bus_a.state_dbg), 32'(CLR_SETUP));
    check("rst_state_b", 32'(bus_b.state_dbg), 32'(IDLE));
    check("rst_b_clr_busy", 32'(bus_b.clr_busy), 32'd0);

    // B: no clear, WR_PULSE=3, RD_WAIT=1
    @(negedge clk);
    rst_b = 1'b1;
    check("b_ready_cycle0", 32'(bus_b.ready), 32'd0);
    @(negedge clk);
    check("b_ready_cycle1", 32'(bus_b.ready), 32'd1);
    check("b_clr_busy", 32'(bus_b.clr_busy), 32'd0);
    access_b(1'b1, 8'h55, 4'h9, lat, wl);
    check("b_wr_latency", 32'(lat), 32'(BWS + BWP + BWH + 1));
    check("b_w_low_cycles", 32'(wl), 32'(BWP));
    access_b(1'b0, 8'h55, 4'h0, lat, wl);
    check("b_rd_latency", 32'(lat), 32'(BRD + 1));
    check("b_rd_w_low", 32'(wl), 32'd0);
    check("b_rd_data", 32'(bus_b.rdata), 32'h9);

    // A: zero-fill, then reads across the array
    release_and_sweep_a();
    access_a(1'b0, 8'h00, 4'h0, 1'b0);
    access_a(1'b0, 8'h7F, 4'h0, 1'b0);
    access_a(1'b0, 8'hFF, 4'h0, 1'b0);

    // directed write / read / hold-through-write
    repeat (2) @(negedge clk);
    access_a(1'b1, 8'h3C, 4'hA, 1'b0);
    repeat (1) @(negedge clk);
    access_a(1'b0, 8'h3C, 4'h0, 1'b0);
    repeat (1) @(negedge clk);
    access_a(1'b1, 8'h44, 4'h3, 1'b0);

    // back-to-back with req held across the done cycle
    repeat (2) @(negedge clk);
    access_a(1'b1, 8'h01, 4'h5, 1'b0);
    access_a(1'b0, 8'h01, 4'h0, 1'b1);

    // randomized traffic on a small address window
    for (int t = 0; t < 60; t++) begin
      wr = 1'($urandom_range(0, 1));
      ad = 8'h80 | 8'($urandom_range(0, 15));
      wd = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) access_a(wr, ad, wd, 1'b1);
      else begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        access_a(wr, ad, wd, 1'b0);
      end
    end

    // reset in the middle of a write pulse
    repeat (2) @(negedge clk);
    bus_a.req = 1'b1; bus_a.we = 1'b1; bus_a.addr = 8'h3C; bus_a.wdata = 4'h6;
    @(posedge clk);
    #1;
    bus_a.req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_w_low_before", 32'(a_w), 32'd0);
    #2;
    rst_a = 1'b0;
    #1;
    check("abort_w", 32'(a_w), 32'd1);
    check("abort_cs1", 32'(a_cs1), 32'd1);
    check("abort_cs2", 32'(a_cs2), 32'd0);
    check("abort_ready", 32'(bus_a.ready), 32'd0);
    check("abort_clr_busy", 32'(bus_a.clr_busy), 32'd1);
    check("abort_ram_a", 32'(a_a), 32'd0);
    last_rd = 4'h0;
    release_and_sweep_a();
    access_a(1'b0, 8'h3C, 4'h0, 1'b0);
    access_a(1'b0, 8'h01, 4'h0, 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, compared %0d mismatched %0d", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
